// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: branch_op encodings, FSM state
// codes and the default fetch address after reset.
//
// Contents:
//   BR_NONE..BR_JR    ID-stage control-transfer encodings (5-7 decode as none)
//   pc_state_t        sequencer FSM states (ST_BOOT, ST_RUN, ST_ERR)
//   RESET_PC_DEFAULT  default fetch address after reset
package pc_sequencer_pkg;

   localparam logic [2:0] BR_NONE = 3'd0;
   localparam logic [2:0] BR_BEQ  = 3'd1;
   localparam logic [2:0] BR_BNE  = 3'd2;
   localparam logic [2:0] BR_J    = 3'd3;
   localparam logic [2:0] BR_JR   = 3'd4;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } pc_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Word offset to byte offset, sign-extended to 32 bits.
   function automatic logic [31:0] sext_word_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_sequencer_npc_calc.sv
// Next-PC calculator: purely combinational branch condition and target
// generation for the instruction currently in ID.
//
// Ports:
//   branch_op   in   3   ID-stage control encoding
//   cmp_eq      in   1   rs == rt from the ID-stage comparator
//   imm16       in   16  branch offset in words
//   j_index     in   26  jump index
//   jr_target   in   32  forwarded rs value for jr
//   if_id_pc4   in   32  PC+4 of the ID-stage instruction
//   taken       out  1   branch condition true (not gated by pipeline state)
//   target      out  32  word-aligned transfer target
//   misaligned  out  1   jr whose target has non-zero low bits
module pc_sequencer_npc_calc
   import pc_sequencer_pkg::*;
(
   input  logic [2:0]  branch_op,
   input  logic        cmp_eq,
   input  logic [15:0] imm16,
   input  logic [25:0] j_index,
   input  logic [31:0] jr_target,
   input  logic [31:0] if_id_pc4,
   output logic        taken,
   output logic [31:0] target,
   output logic        misaligned
);

   logic [31:0] br_target;
   logic [31:0] j_target;
   logic [31:0] jr_aligned;

   assign br_target  = if_id_pc4 + sext_word_offset(imm16);
   assign j_target   = {if_id_pc4[31:28], j_index, 2'b00};
   // Misaligned jr still redirects, but to the word containing the target.
   assign jr_aligned = {jr_target[31:2], 2'b00};

   always_comb begin
      taken  = 1'b0;
      target = br_target;
      case (branch_op)
         BR_BEQ: begin
            taken  = cmp_eq;
            target = br_target;
         end
         BR_BNE: begin
            taken  = ~cmp_eq;
            target = br_target;
         end
         BR_J: begin
            taken  = 1'b1;
            target = j_target;
         end
         BR_JR: begin
            taken  = 1'b1;
            target = jr_aligned;
         end
         default: begin
            taken  = 1'b0;
            target = br_target;
         end
      endcase
   end

   assign misaligned = (branch_op == BR_JR) && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the fetch PC and the IF/ID pipeline register, resolves
// branches in ID using the external equality comparator, and redirects fetch
// with single-delay-slot semantics (the instruction fetched alongside a taken
// branch is always latched into IF/ID, never flushed).
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous active-high reset
//   stall        in   1   hazard stall; freezes PC and IF/ID
//   branch_op    in   3   ID-stage control encoding
//   cmp_eq       in   1   rs == rt for the ID-stage instruction
//   imm16        in   16  branch offset in words
//   j_index      in   26  jump index
//   jr_target    in   32  forwarded rs value for jr
//   instr_in     in   32  instruction memory data at address pc
//   pc           out  32  current fetch address
//   if_id_instr  out  32  instruction presented to ID
//   if_id_pc4    out  32  PC+4 of that instruction
//   if_id_valid  out  1   IF/ID holds a real instruction
//   redirect     out  1   combinational: taken transfer this cycle
//   addr_err     out  1   sticky: misaligned jr target seen
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [2:0]        branch_op,
   input  logic              cmp_eq,
   input  logic [15:0]       imm16,
   input  logic [25:0]       j_index,
   input  logic [31:0]       jr_target,
   input  logic [31:0]       instr_in,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc4,
   output logic              if_id_valid,
   output logic              redirect,
   output logic              addr_err
);

   pc_state_t   state_q;
   logic [31:0] pc_q;
   logic [31:0] if_id_instr_q;
   logic [31:0] if_id_pc4_q;
   logic        if_id_valid_q;
   logic        addr_err_q;

   logic        cond_taken;
   logic [31:0] target;
   logic        misaligned;
   logic        resolve;
   logic        taken;
   logic [31:0] pc_plus4;

   pc_sequencer_npc_calc u_npc_calc (
      .branch_op  (branch_op),
      .cmp_eq     (cmp_eq),
      .imm16      (imm16),
      .j_index    (j_index),
      .jr_target  (jr_target),
      .if_id_pc4  (if_id_pc4_q),
      .taken      (cond_taken),
      .target     (target),
      .misaligned (misaligned)
   );

   // Branches resolve only on a real, unstalled ID instruction while running;
   // a stalled branch is simply re-evaluated on the first unstalled cycle.
   assign resolve  = (state_q == ST_RUN) && if_id_valid_q && !stall;
   assign taken    = resolve && cond_taken;
   assign pc_plus4 = pc_q + 32'd4;  // wraps 0xFFFF_FFFC -> 0

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         if_id_instr_q <= 32'd0;
         if_id_pc4_q   <= 32'd0;
         if_id_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_q <= ST_RUN;
               if (!stall) begin
                  pc_q          <= pc_plus4;
                  if_id_instr_q <= instr_in;
                  if_id_pc4_q   <= pc_plus4;
                  if_id_valid_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  // Delay slot: IF/ID always takes the instruction at pc.
                  if_id_instr_q <= instr_in;
                  if_id_pc4_q   <= pc_plus4;
                  if_id_valid_q <= 1'b1;
                  pc_q          <= taken ? target : pc_plus4;
                  if (taken && misaligned) begin
                     addr_err_q <= 1'b1;
                     state_q    <= ST_ERR;
                  end
               end
            end
            ST_ERR: begin
               // Absorbing: pc frozen, pipeline drained, only reset recovers.
               if_id_valid_q <= 1'b0;
            end
            default: begin
               state_q <= ST_ERR;
            end
         endcase
      end
   end

   assign pc          = pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_pc4   = if_id_pc4_q;
   assign if_id_valid = if_id_valid_q;
   assign redirect    = taken;
   assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a table of per-cycle vectors walked
// from reset, followed by hand-written sequences for mid-run reset, the
// misaligned-jr error state and PC wrap-around.
module tb_pc_sequencer;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [2:0]  branch_op;
   logic        cmp_eq;
   logic [15:0] imm16;
   logic [25:0] j_index;
   logic [31:0] jr_target;
   logic [31:0] instr_in;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        redirect;
   logic        addr_err;

   int n_cmp;
   int n_fail;

   // Instruction memory model: each address yields a distinct word.
   function automatic logic [31:0] im(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
   endfunction

   assign instr_in = im(pc);

   pc_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .branch_op   (branch_op),
      .cmp_eq      (cmp_eq),
      .imm16       (imm16),
      .j_index     (j_index),
      .jr_target   (jr_target),
      .instr_in    (instr_in),
      .pc          (pc),
      .if_id_instr (if_id_instr),
      .if_id_pc4   (if_id_pc4),
      .if_id_valid (if_id_valid),
      .redirect    (redirect),
      .addr_err    (addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [2:0]  op;
      logic        cmp;
      logic [15:0] imm;
      logic [25:0] jidx;
      logic [31:0] jr;
      logic        e_redir;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
      logic [31:0] e_instr;
      logic        e_valid;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [2:0] op, input logic cmp,
                        input logic [15:0] imm, input logic [25:0] jidx,
                        input logic [31:0] jr);
      stall     = st;
      branch_op = op;
      cmp_eq    = cmp;
      imm16     = imm;
      j_index   = jidx;
      jr_target = jr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset pulse away from the clock edge; checks the async reset values.
   task automatic pulse_reset(input string tag);
      drive(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      reset = 1'b1;
      #1;
      chk({tag, " pc"}, pc, 32'h0000_3000);
      chk({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
      chk({tag, " addr_err"}, {31'd0, addr_err}, 32'd0);
      chk({tag, " pc4"}, if_id_pc4, 32'd0);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      reset  = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);

      //            st   op    cmp   imm       jidx        jr            redir pc            pc4           instr           valid
      vecs[0]  = '{1'b0, 3'd3, 1'b0, 16'h0000, 26'h0000C40, 32'h0,        1'b0, 32'h0000_3004, 32'h0000_3004, im(32'h3000), 1'b1};
      vecs[1]  = '{1'b0, 3'd0, 1'b0, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3008, 32'h0000_3008, im(32'h3004), 1'b1};
      vecs[2]  = '{1'b0, 3'd1, 1'b1, 16'hFFFE, 26'h0,       32'h0,        1'b1, 32'h0000_3000, 32'h0000_300C, im(32'h3008), 1'b1};
      vecs[3]  = '{1'b0, 3'd2, 1'b1, 16'h0004, 26'h0,       32'h0,        1'b0, 32'h0000_3004, 32'h0000_3004, im(32'h3000), 1'b1};
      vecs[4]  = '{1'b0, 3'd2, 1'b0, 16'h0004, 26'h0,       32'h0,        1'b1, 32'h0000_3014, 32'h0000_3008, im(32'h3004), 1'b1};
      vecs[5]  = '{1'b0, 3'd0, 1'b0, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3018, 32'h0000_3018, im(32'h3014), 1'b1};
      vecs[6]  = '{1'b1, 3'd1, 1'b1, 16'h0010, 26'h0,       32'h0,        1'b0, 32'h0000_3018, 32'h0000_3018, im(32'h3014), 1'b1};
      vecs[7]  = '{1'b1, 3'd1, 1'b1, 16'h0010, 26'h0,       32'h0,        1'b0, 32'h0000_3018, 32'h0000_3018, im(32'h3014), 1'b1};
      vecs[8]  = '{1'b0, 3'd1, 1'b1, 16'h0010, 26'h0,       32'h0,        1'b1, 32'h0000_3058, 32'h0000_301C, im(32'h3018), 1'b1};
      vecs[9]  = '{1'b0, 3'd3, 1'b0, 16'h0000, 26'h0000C40, 32'h0,        1'b1, 32'h0000_3100, 32'h0000_305C, im(32'h3058), 1'b1};
      vecs[10] = '{1'b0, 3'd4, 1'b0, 16'h0000, 26'h0,       32'h0000_3104, 1'b1, 32'h0000_3104, 32'h0000_3104, im(32'h3100), 1'b1};
      vecs[11] = '{1'b0, 3'd5, 1'b1, 16'h0000, 26'h0,       32'h0,        1'b0, 32'h0000_3108, 32'h0000_3108, im(32'h3104), 1'b1};

      #2;
      chk("reset pc", pc, 32'h0000_3000);
      chk("reset valid", {31'd0, if_id_valid}, 32'd0);
      chk("reset instr", if_id_instr, 32'd0);
      chk("reset pc4", if_id_pc4, 32'd0);
      chk("reset addr_err", {31'd0, addr_err}, 32'd0);
      #10;
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].st, vecs[i].op, vecs[i].cmp, vecs[i].imm, vecs[i].jidx, vecs[i].jr);
         #2;
         chk($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
         tick();
         chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d pc4", i), if_id_pc4, vecs[i].e_pc4);
         chk($sformatf("v%0d instr", i), if_id_instr, vecs[i].e_instr);
         chk($sformatf("v%0d valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      end
      chk("run addr_err", {31'd0, addr_err}, 32'd0);

      // Reset mid-run takes effect immediately, without a clock edge.
      pulse_reset("midrun");

      // Misaligned jr: redirect to the aligned word, then freeze.
      tick();
      tick();
      chk("err pre pc", pc, 32'h0000_3008);
      drive(1'b0, 3'd4, 1'b0, 16'h0, 26'h0, 32'h0000_3101);
      #2;
      chk("err jr redirect", {31'd0, redirect}, 32'd1);
      tick();
      chk("err jr pc", pc, 32'h0000_3100);
      chk("err jr addr_err", {31'd0, addr_err}, 32'd1);
      chk("err jr slot valid", {31'd0, if_id_valid}, 32'd1);
      chk("err jr slot instr", if_id_instr, im(32'h3008));
      drive(1'b0, 3'd3, 1'b0, 16'h0, 26'h0000C40, 32'h0);
      #2;
      chk("err redirect off", {31'd0, redirect}, 32'd0);
      tick();
      chk("err frozen pc", pc, 32'h0000_3100);
      chk("err valid off", {31'd0, if_id_valid}, 32'd0);
      tick();
      chk("err frozen pc2", pc, 32'h0000_3100);
      chk("err sticky", {31'd0, addr_err}, 32'd1);
      pulse_reset("recover");
      tick();
      chk("recover pc", pc, 32'h0000_3004);

      // PC wrap-around at the top of the address space.
      pulse_reset("wrap");
      tick();
      tick();
      drive(1'b0, 3'd4, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC);
      tick();
      chk("wrap top pc", pc, 32'hFFFF_FFFC);
      chk("wrap no err", {31'd0, addr_err}, 32'd0);
      drive(1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
      tick();
      chk("wrap pc", pc, 32'h0000_0000);
      chk("wrap pc4", if_id_pc4, 32'h0000_0000);
      chk("wrap instr", if_id_instr, im(32'hFFFF_FFFC));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
